// File: rtl/issue_sched_pkg.sv
// Shared widths, opcodes, slot state encodings and register-usage decode for issue_sched.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: instr_t (latched instruction fields), reg_use_t (which operands touch which busy table).
package issue_sched_pkg;

   localparam int OPT_WID    = 7;
   localparam int FUNCT3_WID = 3;
   localparam int FUNCT6_WID = 6;
   localparam int REG_WID    = 5;
   localparam int XLEN       = 32;
   localparam int NREG       = 32;

   localparam logic [OPT_WID-1:0] OPCODE_B  = 7'b1100011;
   localparam logic [OPT_WID-1:0] OPCODE_I  = 7'b0010011;
   localparam logic [OPT_WID-1:0] OPCODE_R  = 7'b0110011;
   localparam logic [OPT_WID-1:0] OPCODE_VA = 7'b1010111;
   localparam logic [OPT_WID-1:0] OPCODE_L  = 7'b0000011;
   localparam logic [OPT_WID-1:0] OPCODE_S  = 7'b0100011;
   localparam logic [OPT_WID-1:0] OPCODE_VL = 7'b0000111;
   localparam logic [OPT_WID-1:0] OPCODE_VS = 7'b0100111;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_HOLD    = 2'd1;
   localparam logic [1:0] ST_ISSUE   = 2'd2;
   localparam logic [1:0] ST_WAIT_WB = 2'd3;

   typedef struct packed {
      logic [OPT_WID-1:0]    opt;
      logic [FUNCT3_WID-1:0] funct3;
      logic [FUNCT6_WID-1:0] funct6;
      logic [REG_WID-1:0]    rs1;
      logic [REG_WID-1:0]    rs2;
      logic [REG_WID-1:0]    rd;
      logic [XLEN-1:0]       imm;
   } instr_t;

   // *_en: operand is used; *_vec: operand lives in the vector busy table.
   typedef struct packed {
      logic rs1_en;
      logic rs1_vec;
      logic rs2_en;
      logic rs2_vec;
      logic rd_en;
      logic rd_vec;
   } reg_use_t;

   function automatic logic is_alu(input logic [OPT_WID-1:0] opt);
      return (opt == OPCODE_B) || (opt == OPCODE_I) || (opt == OPCODE_R) || (opt == OPCODE_VA);
   endfunction

   function automatic logic is_ls(input logic [OPT_WID-1:0] opt);
      return (opt == OPCODE_L) || (opt == OPCODE_S) || (opt == OPCODE_VL) || (opt == OPCODE_VS);
   endfunction

   // Bit order: rs1_en rs1_vec rs2_en rs2_vec rd_en rd_vec.
   // Vector memory ops take a scalar base in rs1; VS carries its store data in a vector rs2.
   function automatic reg_use_t reg_use(input logic [OPT_WID-1:0] opt);
      reg_use_t u;
      u = '0;
      case (opt)
         OPCODE_B:  u = 6'b101000;
         OPCODE_I:  u = 6'b100010;
         OPCODE_R:  u = 6'b101010;
         OPCODE_VA: u = 6'b111111;
         OPCODE_L:  u = 6'b100010;
         OPCODE_S:  u = 6'b101000;
         OPCODE_VL: u = 6'b100011;
         OPCODE_VS: u = 6'b101100;
         default:   u = '0;
      endcase
      return u;
   endfunction

endpackage

// File: rtl/issue_sched_slot.sv
// One issue slot: latches an instruction, waits for a hazard-free grant, handshakes it out.
// Latency: load -> HOLD next edge; grant -> valid next edge.
// Backpressure: valid and fields held until ready is sampled high; vacant only in IDLE.
// Ports: load/load_instr (capture), has_dest, go (grant while in HOLD), ready, wb_valid,
//        vacant, hold, valid, instr (latched fields).
module sched_slot
   import issue_sched_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   load,
   input  instr_t load_instr,
   input  logic   has_dest,
   input  logic   go,
   input  logic   ready,
   input  logic   wb_valid,
   output logic   vacant,
   output logic   hold,
   output logic   valid,
   output instr_t instr
);

   logic [1:0] state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         valid <= 1'b0;
         instr <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (load) begin
                  instr <= load_instr;
                  state <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (go) begin
                  valid <= 1'b1;
                  state <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (ready) begin
                  valid <= 1'b0;
                  // Stores and branches never write back, so nothing to wait for.
                  state <= has_dest ? ST_WAIT_WB : ST_IDLE;
               end
            end
            ST_WAIT_WB: begin
               if (wb_valid) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign vacant = (state == ST_IDLE);
   assign hold   = (state == ST_HOLD);

endmodule

// File: rtl/issue_sched.sv
// Two-slot (ALU, LS) in-order issue scheduler with scalar/vector busy tables.
// Latency: ib_valid -> x_valid 2 cycles minimum; +1 after the clearing writeback unless bypassed.
// Backpressure: slot holds its instruction until x_ready; sb_vacant_* low while a slot is occupied.
// Ports: ib_* (instruction in), sb_vacant_* (to i_buffer), alu_*/ls_* (issue handshake + fields),
//        *_wb_* (writeback clears), illegal (unknown opcode pulse).
// Build option: define SCHED_BYPASS_EN to let a same-cycle writeback unblock a HOLD instruction.
module issue_sched
   import issue_sched_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ib_valid,
   input  logic [OPT_WID-1:0]    ib_opt,
   input  logic [FUNCT3_WID-1:0] ib_funct3,
   input  logic [FUNCT6_WID-1:0] ib_funct6,
   input  logic [REG_WID-1:0]    ib_rs1,
   input  logic [REG_WID-1:0]    ib_rs2,
   input  logic [REG_WID-1:0]    ib_rd,
   input  logic [XLEN-1:0]       ib_imm,
   output logic                  sb_vacant_ALU,
   output logic                  sb_vacant_LS,
   output logic                  alu_valid,
   input  logic                  alu_ready,
   output logic [OPT_WID-1:0]    alu_opt,
   output logic [FUNCT3_WID-1:0] alu_funct3,
   output logic [FUNCT6_WID-1:0] alu_funct6,
   output logic [REG_WID-1:0]    alu_rs1,
   output logic [REG_WID-1:0]    alu_rs2,
   output logic [REG_WID-1:0]    alu_rd,
   output logic [XLEN-1:0]       alu_imm,
   output logic                  ls_valid,
   input  logic                  ls_ready,
   output logic [OPT_WID-1:0]    ls_opt,
   output logic [FUNCT3_WID-1:0] ls_funct3,
   output logic [FUNCT6_WID-1:0] ls_funct6,
   output logic [REG_WID-1:0]    ls_rs1,
   output logic [REG_WID-1:0]    ls_rs2,
   output logic [REG_WID-1:0]    ls_rd,
   output logic [XLEN-1:0]       ls_imm,
   input  logic                  alu_wb_valid,
   input  logic [REG_WID-1:0]    alu_wb_rd,
   input  logic                  alu_wb_vec,
   input  logic                  ls_wb_valid,
   input  logic [REG_WID-1:0]    ls_wb_rd,
   input  logic                  ls_wb_vec,
   output logic                  illegal
);

   instr_t          ib_instr, alu_i, ls_i;
   reg_use_t        alu_use, ls_use;
   logic            alu_hold, ls_hold, alu_go, ls_go, alu_set, ls_set;
   logic            alu_haz, ls_haz, ls_conflict;
   logic [NREG-1:0] busy_s, busy_v, set_s, set_v, clr_s, clr_v, haz_s, haz_v;

   function automatic logic reg_busy(input logic vec, input logic [REG_WID-1:0] r,
                                     input logic [NREG-1:0] hs, input logic [NREG-1:0] hv);
      return vec ? hv[r] : hs[r];
   endfunction

   function automatic logic hazard(input reg_use_t u, input logic [REG_WID-1:0] rs1,
                                   input logic [REG_WID-1:0] rs2, input logic [REG_WID-1:0] rd,
                                   input logic [NREG-1:0] hs, input logic [NREG-1:0] hv);
      return (u.rs1_en && reg_busy(u.rs1_vec, rs1, hs, hv)) ||
             (u.rs2_en && reg_busy(u.rs2_vec, rs2, hs, hv)) ||
             (u.rd_en  && reg_busy(u.rd_vec,  rd,  hs, hv));
   endfunction

   // True when the instruction reads or writes register r of the given table.
   function automatic logic touches(input reg_use_t u, input logic [REG_WID-1:0] rs1,
                                    input logic [REG_WID-1:0] rs2, input logic [REG_WID-1:0] rd,
                                    input logic vec, input logic [REG_WID-1:0] r);
      return (u.rs1_en && (u.rs1_vec == vec) && (rs1 == r)) ||
             (u.rs2_en && (u.rs2_vec == vec) && (rs2 == r)) ||
             (u.rd_en  && (u.rd_vec  == vec) && (rd  == r));
   endfunction

   assign ib_instr = {ib_opt, ib_funct3, ib_funct6, ib_rs1, ib_rs2, ib_rd, ib_imm};

   sched_slot u_alu (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (ib_valid && is_alu(ib_opt) && sb_vacant_ALU),
      .load_instr (ib_instr),
      .has_dest   (alu_use.rd_en),
      .go         (alu_go),
      .ready      (alu_ready),
      .wb_valid   (alu_wb_valid),
      .vacant     (sb_vacant_ALU),
      .hold       (alu_hold),
      .valid      (alu_valid),
      .instr      (alu_i)
   );

   sched_slot u_ls (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (ib_valid && is_ls(ib_opt) && sb_vacant_LS),
      .load_instr (ib_instr),
      .has_dest   (ls_use.rd_en),
      .go         (ls_go),
      .ready      (ls_ready),
      .wb_valid   (ls_wb_valid),
      .vacant     (sb_vacant_LS),
      .hold       (ls_hold),
      .valid      (ls_valid),
      .instr      (ls_i)
   );

   assign {alu_opt, alu_funct3, alu_funct6, alu_rs1, alu_rs2, alu_rd, alu_imm} = alu_i;
   assign {ls_opt,  ls_funct3,  ls_funct6,  ls_rs1,  ls_rs2,  ls_rd,  ls_imm}  = ls_i;

   assign alu_use = reg_use(alu_i.opt);
   assign ls_use  = reg_use(ls_i.opt);

   always_comb begin
      clr_s = '0;
      clr_v = '0;
      if (alu_wb_valid) begin
         if (alu_wb_vec) clr_v[alu_wb_rd] = 1'b1;
         else            clr_s[alu_wb_rd] = 1'b1;
      end
      if (ls_wb_valid) begin
         if (ls_wb_vec) clr_v[ls_wb_rd] = 1'b1;
         else           clr_s[ls_wb_rd] = 1'b1;
      end
   end

`ifdef SCHED_BYPASS_EN
   assign haz_s = busy_s & ~clr_s;
   assign haz_v = busy_v & ~clr_v;
`else
   assign haz_s = busy_s;
   assign haz_v = busy_v;
`endif

   assign alu_haz = hazard(alu_use, alu_rs1, alu_rs2, alu_rd, haz_s, haz_v);
   assign ls_haz  = hazard(ls_use,  ls_rs1,  ls_rs2,  ls_rd,  haz_s, haz_v);

   // Scalar x0 is never marked busy.
   assign alu_go  = alu_hold && !alu_haz;
   assign alu_set = alu_go && alu_use.rd_en && (alu_use.rd_vec || (alu_rd != '0));

   // ALU wins a same-edge race: its new rd is not yet in the table, so check it directly.
   assign ls_conflict = alu_set && touches(ls_use, ls_rs1, ls_rs2, ls_rd, alu_use.rd_vec, alu_rd);
   assign ls_go  = ls_hold && !ls_haz && !ls_conflict;
   assign ls_set = ls_go && ls_use.rd_en && (ls_use.rd_vec || (ls_rd != '0));

   always_comb begin
      set_s = '0;
      set_v = '0;
      if (alu_set) begin
         if (alu_use.rd_vec) set_v[alu_rd] = 1'b1;
         else                set_s[alu_rd] = 1'b1;
      end
      if (ls_set) begin
         if (ls_use.rd_vec) set_v[ls_rd] = 1'b1;
         else               set_s[ls_rd] = 1'b1;
      end
   end

   // A new owner issuing on the same edge as the old owner's writeback keeps the bit set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_s  <= '0;
         busy_v  <= '0;
         illegal <= 1'b0;
      end else begin
         busy_s  <= (busy_s & ~clr_s) | set_s;
         busy_v  <= (busy_v & ~clr_v) | set_v;
         illegal <= ib_valid && !is_alu(ib_opt) && !is_ls(ib_opt);
      end
   end

endmodule
